// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional stall counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int unsigned     WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int unsigned     PERF_WIDTH  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0] stall_cycles_o
`endif
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= EMPTY;
      main_q     <= RESET_VALUE;
      skid_q     <= RESET_VALUE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      // Registered from next state so out_ready never reaches in_ready combinationally.
      in_ready_q <= (state_d != FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          main_d  = in_data_i;
          state_d = BUSY;
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            skid_d  = in_data_i;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid_o = (state_q != EMPTY);
    out_data_o  = main_q;
    in_ready_o  = in_ready_q;
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [PERF_WIDTH-1:0] stall_q;

  // Saturating; flush deliberately leaves the count alone.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      stall_q <= '0;
    else if (out_valid_o && !out_ready_i && (stall_q != {PERF_WIDTH{1'b1}}))
      stall_q <= stall_q + 1'b1;
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, back-pressure, flush, async reset, stall counter.
module tb_pipe_stage_skid;

  localparam int unsigned     W    = 8;
  localparam logic [W-1:0]    RV   = 8'h5A;
  localparam int unsigned     PW   = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [PW-1:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(.WIDTH(W), .RESET_VALUE(RV), .PERF_WIDTH(PW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cycles_o (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset held for 3 cycles
    tick(); tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  {24'd0, out_data},  {24'd0, RV});
    rst_n = 1'b1;
    tick();
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Streaming 0x11,0x22,0x33
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    tick();
    chk("s1_valid", {31'd0, out_valid}, 32'd1);
    chk("s1_data",  {24'd0, out_data},  32'h11);
    chk("s1_ready", {31'd0, in_ready},  32'd1);
    in_data = 8'h22;
    tick();
    chk("s2_data",  {24'd0, out_data},  32'h22);
    chk("s2_ready", {31'd0, in_ready},  32'd1);
    in_data = 8'h33;
    tick();
    chk("s3_data",  {24'd0, out_data},  32'h33);
    chk("s3_ready", {31'd0, in_ready},  32'd1);
    in_valid = 1'b0; in_data = 8'hEE;
    tick();
    chk("s_drain_valid", {31'd0, out_valid}, 32'd0);

    // Back-pressure: 0xA0, 0xA1 fill main + skid
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA0;
    tick();
    chk("bp1_ready", {31'd0, in_ready}, 32'd1);
    in_data = 8'hA1;
    tick();
    chk("bp_full_ready", {31'd0, in_ready},  32'd0);
    chk("bp_full_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_full_data",  {24'd0, out_data},  32'hA0);
    in_valid = 1'b0; in_data = 8'hFF;
    tick();
    chk("bp_hold_data",  {24'd0, out_data},  32'hA0);
    chk("bp_hold_ready", {31'd0, in_ready},  32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1_data",  {24'd0, out_data},  32'hA1);
    chk("bp_pop1_ready", {31'd0, in_ready},  32'd1);
    tick();
    chk("bp_empty_valid", {31'd0, out_valid}, 32'd0);

    // Flush while FULL with in_valid high
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hB0;
    tick();
    in_data = 8'hB1;
    tick();
    chk("fl_pre_ready", {31'd0, in_ready}, 32'd0);
    in_data = 8'hB2; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready},  32'd1);
    chk("fl_data",  {24'd0, out_data},  {24'd0, RV});
    out_ready = 1'b1;
    tick();
    chk("fl_no_ghost", {31'd0, out_valid}, 32'd0);

    // Flush in BUSY while an input beat fires: beat is discarded
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC0;
    tick();
    in_data = 8'hC1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flb_valid", {31'd0, out_valid}, 32'd0);
    chk("flb_data",  {24'd0, out_data},  {24'd0, RV});
    chk("flb_ready", {31'd0, in_ready},  32'd1);

    // Async reset mid-stream, asserted between edges
    in_valid = 1'b1; in_data = 8'hD0;
    tick();
    in_valid = 1'b0;
    chk("ar_busy", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_now", {31'd0, out_valid}, 32'd0);
    chk("ar_data_now",  {24'd0, out_data},  {24'd0, RV});
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("ar_no_stale", {31'd0, out_valid}, 32'd0);
    chk("ar_ready",    {31'd0, in_ready},  32'd1);

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter saturation at PERF_WIDTH=4
    chk("pf_rst", {28'd0, stall_cycles}, 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hE0;
    tick();
    in_valid = 1'b0;
    chk("pf_load", {28'd0, stall_cycles}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("pf_5", {28'd0, stall_cycles}, 32'd5);
    for (int i = 0; i < 15; i++) tick();
    chk("pf_sat", {28'd0, stall_cycles}, 32'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pf_flush", {28'd0, stall_cycles}, 32'd15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register with a full valid/ready handshake and a 2-entry skid buffer.
- Successor to the fixed stall-driven stage registers between pipeline stages (e.g. MEM->WB). Carries an arbitrary packed bundle of WIDTH bits.
- Supports back-pressure without combinational ready paths and a synchronous flush for exceptions and branch mispredicts.
- Sits between any two pipeline stages; one instance replaces a bank of per-signal flops.

Parameters:
- WIDTH, 32: payload width in bits, >=1.
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into both data registers at reset and on flush.
- PERF_WIDTH, 16: width of the stall counter; used only with PIPE_STAGE_PERF_EN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; driven directly from a flop.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream payload valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  downstream payload; driven from the main register.
- stall_cycles  output  PERF_WIDTH  back-pressure cycle count; port present only with PIPE_STAGE_PERF_EN.

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - Main register: main_q.
  - Skid register: skid_q.
  - State register with three states: EMPTY, BUSY (main_q valid), FULL (main_q and skid_q valid).
- Outputs:
  - out_valid = (state != EMPTY).
  - out_data = main_q.
  - in_ready is a flop equal to (next_state != FULL). There is no combinational path from out_ready to in_ready.
- Transitions when flush=0:
  - EMPTY, in_fire: main_q<=in_data; go to BUSY.
  - EMPTY, otherwise: stay in EMPTY.
  - BUSY, in_fire & out_fire: main_q<=in_data; stay in BUSY.
  - BUSY, in_fire & !out_fire: skid_q<=in_data; go to FULL. in_ready goes to 0 next cycle.
  - BUSY, !in_fire & out_fire: go to EMPTY.
  - BUSY, otherwise: hold.
  - FULL, out_fire: main_q<=skid_q; go to BUSY. in_ready goes to 1 next cycle.
  - FULL, otherwise: hold. in_fire cannot occur in FULL because in_ready=0.
- Flush:
  - flush=1 has highest priority: state<=EMPTY, main_q<=RESET_VALUE, skid_q<=RESET_VALUE, in_ready<=1.
  - Any in_fire or out_fire in the flush cycle still completes as a handshake, but the accepted input is discarded.
- Latency and throughput:
  - in_fire to out_valid is 1 cycle from EMPTY.
  - Sustained throughput is 1 beat per cycle while out_ready=1.
  - Order is strictly FIFO; no beat is dropped or duplicated outside flush.
- Stability:
  - While out_valid & !out_ready, out_data and out_valid hold unchanged until out_fire or flush.
  - Data registers update only on the events listed above; no X propagation from in_data when in_valid=0.
- Reset (asynchronous assert, synchronous release):
  - state=EMPTY, out_valid=0, out_data=RESET_VALUE, skid_q=RESET_VALUE, in_ready=1.
  - Assertion mid-transfer discards all held entries immediately.
- Upstream rules: upstream may change in_data freely while in_valid=0. in_valid may not be withdrawn before in_fire; this is a bench assertion only, not enforced in RTL.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cycles increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at {PERF_WIDTH{1'b1}}.
  - Reset to 0 by rst only; unaffected by flush.
- Undefined: the stall_cycles port and counter logic are absent; behaviour otherwise identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> out_valid=0, in_ready=1, out_data=RESET_VALUE.
- Streaming: out_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles 1,2,3 after the first in_fire; in_ready stays 1.
- Back-pressure: out_ready=0, send 0xA0 then 0xA1 -> state FULL and in_ready=0 after the second beat. Raise out_ready -> 0xA0 then 0xA1 delivered in order, in_ready=1 one cycle after the first out_fire.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_data=RESET_VALUE; the beat presented during flush never appears at the output.
- Async reset mid-stream: drop rst between clock edges while BUSY -> out_valid=0 before the next edge; no stale beat after release.
- PIPE_STAGE_PERF_EN with PERF_WIDTH=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles=15 (saturated); flush leaves it at 15.
